// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: opcodes, flag bit positions
// and the packed layout of one buffered entry.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_NOR  = 3'd7;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_V = 3;

    localparam int unsigned ENTRY_W = 11;

    typedef struct packed {
        logic [3:0] result;
        logic [2:0] op;
        logic [3:0] flags;
    } entry_t;

    function automatic entry_t make_entry(logic [3:0] result, logic [2:0] op, logic [3:0] flags);
        entry_t e;
        e.result = result;
        e.op     = op;
        e.flags  = flags;
        return e;
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generator: derives {V,C,N,Z} from the ALU
// operands, opcode and the result the ALU produced.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [2:0] i_op,
    input  logic [3:0] i_result,
    output logic [3:0] o_flags
);

    logic w_carry_add;
    logic w_borrow_sub;
    logic w_ovf_add;
    logic w_ovf_sub;

    // Carry is evaluated in 5 bits so the overflow out of bit 3 is visible.
    assign w_carry_add  = ({1'b0, i_a} + {1'b0, i_b}) >= 5'd16;
    assign w_borrow_sub = (i_a < i_b);
    assign w_ovf_add    = (i_a[3] == i_b[3]) && (i_result[3] != i_a[3]);
    assign w_ovf_sub    = (i_a[3] != i_b[3]) && (i_result[3] != i_a[3]);

    always_comb begin
        o_flags        = '0;
        o_flags[FLG_Z] = (i_result == 4'd0);
        o_flags[FLG_N] = i_result[3];
        case (i_op)
            OP_ADD: begin
                o_flags[FLG_C] = w_carry_add;
                o_flags[FLG_V] = w_ovf_add;
            end
            OP_SUB: begin
                o_flags[FLG_C] = w_borrow_sub;
                o_flags[FLG_V] = w_ovf_sub;
            end
            default: begin
                o_flags[FLG_C] = 1'b0;
                o_flags[FLG_V] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered FIFO stage behind the 4-bit ALU with flag capture and a
// valid/ready output. ALU_STAT_EN adds the saturating stat_retired counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [2:0]       in_op,
    input  logic [3:0]       in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_result,
    output logic [2:0]       out_op,
    output logic [3:0]       out_flags
`ifdef ALU_STAT_EN
    ,
    output logic [CNT_W-1:0] stat_retired
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("alu_result_stage: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FILL_W-1:0]  r_count;

    logic [3:0]         w_flags;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    entry_t             w_head;

    alu_flag_gen u_flag_gen (
        .i_a      (in_a),
        .i_b      (in_b),
        .i_op     (in_op),
        .i_result (in_result),
        .o_flags  (w_flags)
    );

    // in_ready is a pure function of occupancy, so a pop never opens a
    // slot for the same edge.
    assign w_full   = (r_count == FILL_MAX);
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_pop    = !w_empty && out_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= make_entry(in_result, in_op, w_flags);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FILL_ONE;
                2'b01:   r_count <= r_count - FILL_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = !w_empty;

    // Storage is never cleared, so outputs are gated to read zero when empty.
    always_comb begin
        out_result = '0;
        out_op     = '0;
        out_flags  = '0;
        if (!w_empty) begin
            out_result = w_head.result;
            out_op     = w_head.op;
            out_flags  = w_head.flags;
        end
    end

`ifdef ALU_STAT_EN
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_pop && (r_retired != '1)) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign stat_retired = r_retired;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage; build with ALU_STAT_EN defined to
// also exercise the retired-op counter.
module tb_alu_result_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] in_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [2:0] out_op;
    logic [3:0] out_flags;
`ifdef ALU_STAT_EN
    logic [CNT_W-1:0] stat_retired;
`endif

    alu_result_stage #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .in_result    (in_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_op       (out_op),
        .out_flags    (out_flags)
`ifdef ALU_STAT_EN
        ,
        .stat_retired (stat_retired)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [10:0] sb_q[$];
    int          stat_exp = 0;
    bit          armed = 1'b0;
    int          occ;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu(logic [2:0] op, logic [3:0] a, logic [3:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // Flags from signed/unsigned integer range checks, returned as {V,C,N,Z}.
    function automatic logic [3:0] exp_flags(logic [2:0] op, logic [3:0] a, logic [3:0] b, logic [3:0] r);
        int sa, sb, s;
        logic c, v;
        c  = 1'b0;
        v  = 1'b0;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        if (op == 3'd0) begin
            c = (int'(a) + int'(b)) > 15;
            s = sa + sb;
            v = (s > 7) || (s < -8);
        end else if (op == 3'd1) begin
            c = int'(a) < int'(b);
            s = sa - sb;
            v = (s > 7) || (s < -8);
        end
        return {v, c, r[3], r == 4'd0};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            stat_exp = 0;
            armed    = 1'b1;
        end else begin
            occ = sb_q.size();
            if (occ > 0 && out_ready) begin
                void'(sb_q.pop_front());
                if (stat_exp < (2 ** CNT_W) - 1) stat_exp++;
            end
            if (occ < DEPTH && in_valid) begin
                sb_q.push_back({in_result, in_op, exp_flags(in_op, in_a, in_b, in_result)});
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(sb_q.size() < DEPTH));
            if (sb_q.size() != 0) begin
                check("out_result", 32'(out_result), 32'(sb_q[0][10:7]));
                check("out_op", 32'(out_op), 32'(sb_q[0][6:4]));
                check("out_flags", 32'(out_flags), 32'(sb_q[0][3:0]));
            end else begin
                check("idle_zero", 32'({out_result, out_op, out_flags}), 32'd0);
            end
`ifdef ALU_STAT_EN
            check("stat_retired", 32'(stat_retired), 32'(stat_exp));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [2:0] op, logic [3:0] a, logic [3:0] b);
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_result = alu(op, a, b);
    endtask

    task automatic drive_rand();
        drive(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        drive(3'd0, 4'd3, 4'd4);
        repeat (2) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flags", 32'(out_flags), 32'd0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // ADD 7+1=8: V=1 C=0 N=1 Z=0
        drive(3'd0, 4'd7, 4'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("add_result", 32'(out_result), 32'd8);
        check("add_flags", 32'(out_flags), 32'b1010);
        step();

        // SUB 2-3=F then ADD F+1=0
        drive(3'd1, 4'd2, 4'd3);
        in_valid = 1'b1;
        step();
        check("sub_flags", 32'(out_flags), 32'b0110);
        drive(3'd0, 4'hF, 4'd1);
        step();
        in_valid = 1'b0;
        check("addz_flags", 32'(out_flags), 32'b0101);
        step();

        // Back-pressure: fill, then an extra push that must be dropped
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand();
            in_valid = 1'b1;
            step();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(3'd4, 4'hA, 4'h5);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) step();

        // Streaming with pointer wrap
        for (int i = 0; i < 16; i++) begin
            drive_rand();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        step();

        // Reset with entries buffered
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_rand();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
